// File: rtl/pa_idu_gpr_wb_arb.sv
// GPR writeback arbiter: EX owns write port 0; LSU and DIV share port 1 through
// one-entry holding buffers with LSU priority and a starvation guard for DIV.
module pa_idu_gpr_wb_arb #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        ex_wb_vld,
    input  logic [4:0]  ex_wb_rd,
    input  logic [31:0] ex_wb_data,
    input  logic        lsu_wb_vld,
    input  logic [4:0]  lsu_wb_rd,
    input  logic [31:0] lsu_wb_data,
    output logic        lsu_wb_rdy,
    input  logic        div_wb_vld,
    input  logic [4:0]  div_wb_rd,
    input  logic [31:0] div_wb_data,
    output logic        div_wb_rdy,
    output logic        wb0_vld,
    output logic [4:0]  wb0_rd,
    output logic [31:0] wb0_data,
    output logic        wb1_vld,
    output logic [4:0]  wb1_rd,
    output logic [31:0] wb1_data,
    output logic        wb1_src,
    output logic [1:0]  wb_pending,
    output logic        wb_conflict_err
);

    typedef enum logic [0:0] {
        ARB_LSU = 1'b0,
        ARB_DIV = 1'b1
    } arb_state_e;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_s;
    logic              lsu_full_q, lsu_full_d;
    logic [4:0]        lsu_rd_q, lsu_rd_d;
    logic [31:0]       lsu_data_q, lsu_data_d;
    logic              div_full_q, div_full_d;
    logic [4:0]        div_rd_q, div_rd_d;
    logic [31:0]       div_data_q, div_data_d;
    logic              err_q, err_d;
    logic              grant_lsu_s, grant_div_s;
    logic              lsu_acc_s, div_acc_s;

    // Port-1 grant decision from registered buffer state and arbiter state
    always_comb begin
        grant_lsu_s = 1'b0;
        grant_div_s = 1'b0;
        case (state_q)
            ARB_LSU: begin
                if (lsu_full_q) begin
                    grant_lsu_s = 1'b1;
                end else if (div_full_q) begin
                    grant_div_s = 1'b1;
                end else begin
                    grant_lsu_s = 1'b0;
                    grant_div_s = 1'b0;
                end
            end
            ARB_DIV: grant_div_s = div_full_q;
            default: begin
                grant_lsu_s = 1'b0;
                grant_div_s = 1'b0;
            end
        endcase
    end

    assign lsu_wb_rdy = ~lsu_full_q | grant_lsu_s;
    assign div_wb_rdy = ~div_full_q | grant_div_s;
    assign lsu_acc_s  = lsu_wb_vld & lsu_wb_rdy;
    assign div_acc_s  = div_wb_vld & div_wb_rdy;

    assign wb0_vld  = ex_wb_vld & (ex_wb_rd != 5'd0);
    assign wb0_rd   = wb0_vld ? ex_wb_rd : 5'd0;
    assign wb0_data = wb0_vld ? ex_wb_data : 32'd0;

    assign wb1_vld  = grant_lsu_s | grant_div_s;
    assign wb1_src  = grant_div_s;
    assign wb1_rd   = grant_lsu_s ? lsu_rd_q   : (grant_div_s ? div_rd_q   : 5'd0);
    assign wb1_data = grant_lsu_s ? lsu_data_q : (grant_div_s ? div_data_q : 32'd0);

    assign wb_pending      = {1'b0, lsu_full_q} + {1'b0, div_full_q};
    assign wb_conflict_err = err_q;

    // Holding-buffer next state: refill wins over drain; x0 destinations never occupy a buffer
    always_comb begin
        lsu_rd_d   = lsu_rd_q;
        lsu_data_d = lsu_data_q;
        div_rd_d   = div_rd_q;
        div_data_d = div_data_q;
        if (lsu_acc_s) begin
            lsu_full_d = (lsu_wb_rd != 5'd0);
            lsu_rd_d   = lsu_wb_rd;
            lsu_data_d = lsu_wb_data;
        end else if (grant_lsu_s) begin
            lsu_full_d = 1'b0;
        end else begin
            lsu_full_d = lsu_full_q;
        end
        if (div_acc_s) begin
            div_full_d = (div_wb_rd != 5'd0);
            div_rd_d   = div_wb_rd;
            div_data_d = div_wb_data;
        end else if (grant_div_s) begin
            div_full_d = 1'b0;
        end else begin
            div_full_d = div_full_q;
        end
    end

    // Starvation counter, arbiter transitions and conflict detection
    always_comb begin
        cnt_inc_s = (cnt_q >= STARVE_LIM) ? STARVE_LIM : (cnt_q + CNT_W'(1));
        if (grant_div_s) begin
            cnt_d = '0;
        end else if (div_full_q) begin
            cnt_d = cnt_inc_s;
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            ARB_LSU: begin
                if (div_full_q & ~grant_div_s & (cnt_inc_s == STARVE_LIM)) begin
                    state_d = ARB_DIV;
                end else begin
                    state_d = ARB_LSU;
                end
            end
            ARB_DIV: state_d = ARB_LSU;
            default: state_d = ARB_LSU;
        endcase
        err_d = wb0_vld & wb1_vld & (wb0_rd == wb1_rd);
    end

    // State registers
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q    <= ARB_LSU;
            cnt_q      <= '0;
            lsu_full_q <= 1'b0;
            lsu_rd_q   <= 5'd0;
            lsu_data_q <= 32'd0;
            div_full_q <= 1'b0;
            div_rd_q   <= 5'd0;
            div_data_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lsu_full_q <= lsu_full_d;
            lsu_rd_q   <= lsu_rd_d;
            lsu_data_q <= lsu_data_d;
            div_full_q <= div_full_d;
            div_rd_q   <= div_rd_d;
            div_data_q <= div_data_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_pa_idu_gpr_wb_arb.sv
// Bench for pa_idu_gpr_wb_arb: directed vector table, hand sequences for
// starvation and mid-traffic reset, then random traffic against a queue model.
module tb_pa_idu_gpr_wb_arb;

    localparam int STARVE_MAX = 4;

    logic        clk, cpurst;
    logic        ex_wb_vld, lsu_wb_vld, div_wb_vld;
    logic [4:0]  ex_wb_rd, lsu_wb_rd, div_wb_rd;
    logic [31:0] ex_wb_data, lsu_wb_data, div_wb_data;
    logic        lsu_wb_rdy, div_wb_rdy;
    logic        wb0_vld, wb1_vld, wb1_src, wb_conflict_err;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_data, wb1_data;
    logic [1:0]  wb_pending;

    int checks = 0;
    int errors = 0;

    pa_idu_gpr_wb_arb #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
        .forever_cpuclk(clk), .cpurst(cpurst),
        .ex_wb_vld(ex_wb_vld), .ex_wb_rd(ex_wb_rd), .ex_wb_data(ex_wb_data),
        .lsu_wb_vld(lsu_wb_vld), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
        .lsu_wb_rdy(lsu_wb_rdy),
        .div_wb_vld(div_wb_vld), .div_wb_rd(div_wb_rd), .div_wb_data(div_wb_data),
        .div_wb_rdy(div_wb_rdy),
        .wb0_vld(wb0_vld), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
        .wb1_vld(wb1_vld), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_src(wb1_src),
        .wb_pending(wb_pending), .wb_conflict_err(wb_conflict_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ex_v;  logic [4:0] ex_rd; logic [31:0] ex_d;
        logic        l_v;   logic [4:0] l_rd;  logic [31:0] l_d;
        logic        d_v;   logic [4:0] d_rd;  logic [31:0] d_d;
        logic        o0_v;  logic [4:0] o0_rd; logic [31:0] o0_d;
        logic        o1_v;  logic       o1_src; logic [4:0] o1_rd; logic [31:0] o1_d;
        logic [1:0]  pend;  logic       lrdy;  logic drdy; logic err;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    vec_t tbl[15];
    ent_t lq[$];
    ent_t dq[$];

    // ex/l/d/o0 = {vld, rd}; o1 = {vld, src, rd}; misc = {pending, lsu_rdy, div_rdy, err}
    function automatic vec_t mk(input logic [5:0] ex, input logic [31:0] exd,
                                input logic [5:0] l, input logic [31:0] ld,
                                input logic [5:0] d, input logic [31:0] dd,
                                input logic [5:0] o0, input logic [31:0] o0d,
                                input logic [6:0] o1, input logic [31:0] o1d,
                                input logic [4:0] misc);
        vec_t v;
        v.ex_v = ex[5]; v.ex_rd = ex[4:0]; v.ex_d = exd;
        v.l_v  = l[5];  v.l_rd  = l[4:0];  v.l_d  = ld;
        v.d_v  = d[5];  v.d_rd  = d[4:0];  v.d_d  = dd;
        v.o0_v = o0[5]; v.o0_rd = o0[4:0]; v.o0_d = o0d;
        v.o1_v = o1[6]; v.o1_src = o1[5];  v.o1_rd = o1[4:0]; v.o1_d = o1d;
        v.pend = misc[4:3]; v.lrdy = misc[2]; v.drdy = misc[1]; v.err = misc[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                         input logic dv, input logic [4:0] dr, input logic [31:0] dd);
        ex_wb_vld = ev;  ex_wb_rd = er;  ex_wb_data = ed;
        lsu_wb_vld = lv; lsu_wb_rd = lr; lsu_wb_data = ld;
        div_wb_vld = dv; div_wb_rd = dr; div_wb_data = dd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic starve_seq(input int iter);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h100, 1'b1, 5'd20, 32'hD1D1_0000 + 32'(iter));
        @(negedge clk);
        chk("stv_start_pend", 32'(wb_pending), 32'd0);
        tick();
        div_wb_vld = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            lsu_wb_rd = 5'(10 + k);
            lsu_wb_data = 32'h100 + 32'(k);
            @(negedge clk);
            chk($sformatf("stv%0d_k%0d_wb1_vld", iter, k), 32'(wb1_vld), 32'd1);
            if (k < 5) begin
                chk($sformatf("stv%0d_k%0d_src", iter, k), 32'(wb1_src), 32'd0);
                chk($sformatf("stv%0d_k%0d_rd", iter, k), 32'(wb1_rd), 32'(10 + k - 1));
                chk($sformatf("stv%0d_k%0d_div_rdy", iter, k), 32'(div_wb_rdy), 32'd0);
                chk($sformatf("stv%0d_k%0d_lsu_rdy", iter, k), 32'(lsu_wb_rdy), 32'd1);
            end else begin
                chk($sformatf("stv%0d_win_src", iter), 32'(wb1_src), 32'd1);
                chk($sformatf("stv%0d_win_rd", iter), 32'(wb1_rd), 32'd20);
                chk($sformatf("stv%0d_win_data", iter), wb1_data, 32'hD1D1_0000 + 32'(iter));
                chk($sformatf("stv%0d_win_lsu_rdy", iter), 32'(lsu_wb_rdy), 32'd0);
            end
            tick();
        end
        @(negedge clk);
        chk("stv_after_rd", 32'(wb1_rd), 32'd14);
        chk("stv_after_lsu_rdy", 32'(lsu_wb_rdy), 32'd1);
        chk("stv_after_pend", 32'(wb_pending), 32'd1);
        tick();
        lsu_wb_vld = 1'b0;
        @(negedge clk);
        chk("stv_held_rd", 32'(wb1_rd), 32'd15);
        tick();
        @(negedge clk);
        chk("stv_drain_pend", 32'(wb_pending), 32'd0);
        chk("stv_drain_vld", 32'(wb1_vld), 32'd0);
        tick();
    endtask

    initial begin
        logic        l_acc, d_acc, prev_conf, m_gl, m_gd, e0v, e1v;
        logic [4:0]  e0rd, e1rd;
        logic [31:0] e0d, e1d;
        int          losses, lrate;

        tbl[0]  = mk({1'b1,5'd5}, 32'h12345678, 6'd0, 32'd0, 6'd0, 32'd0,
                     {1'b1,5'd5}, 32'h12345678, 7'd0, 32'd0, 5'b00110);
        tbl[1]  = mk({1'b1,5'd0}, 32'h0000AAAA, 6'd0, 32'd0, 6'd0, 32'd0,
                     6'd0, 32'd0, 7'd0, 32'd0, 5'b00110);
        tbl[2]  = mk(6'd0, 32'd0, {1'b1,5'd7}, 32'hDEADBEEF, 6'd0, 32'd0,
                     6'd0, 32'd0, 7'd0, 32'd0, 5'b00110);
        tbl[3]  = mk(6'd0, 32'd0, 6'd0, 32'd0, 6'd0, 32'd0,
                     6'd0, 32'd0, {1'b1,1'b0,5'd7}, 32'hDEADBEEF, 5'b01110);
        tbl[4]  = mk(6'd0, 32'd0, 6'd0, 32'd0, 6'd0, 32'd0,
                     6'd0, 32'd0, 7'd0, 32'd0, 5'b00110);
        tbl[5]  = mk(6'd0, 32'd0, {1'b1,5'd3}, 32'h33, {1'b1,5'd4}, 32'h44,
                     6'd0, 32'd0, 7'd0, 32'd0, 5'b00110);
        tbl[6]  = mk(6'd0, 32'd0, 6'd0, 32'd0, 6'd0, 32'd0,
                     6'd0, 32'd0, {1'b1,1'b0,5'd3}, 32'h33, 5'b10100);
        tbl[7]  = mk(6'd0, 32'd0, 6'd0, 32'd0, 6'd0, 32'd0,
                     6'd0, 32'd0, {1'b1,1'b1,5'd4}, 32'h44, 5'b01110);
        tbl[8]  = mk(6'd0, 32'd0, 6'd0, 32'd0, 6'd0, 32'd0,
                     6'd0, 32'd0, 7'd0, 32'd0, 5'b00110);
        tbl[9]  = mk(6'd0, 32'd0, {1'b1,5'd9}, 32'h99, 6'd0, 32'd0,
                     6'd0, 32'd0, 7'd0, 32'd0, 5'b00110);
        tbl[10] = mk({1'b1,5'd9}, 32'h1111, 6'd0, 32'd0, 6'd0, 32'd0,
                     {1'b1,5'd9}, 32'h1111, {1'b1,1'b0,5'd9}, 32'h99, 5'b01110);
        tbl[11] = mk(6'd0, 32'd0, 6'd0, 32'd0, 6'd0, 32'd0,
                     6'd0, 32'd0, 7'd0, 32'd0, 5'b00111);
        tbl[12] = mk(6'd0, 32'd0, 6'd0, 32'd0, 6'd0, 32'd0,
                     6'd0, 32'd0, 7'd0, 32'd0, 5'b00110);
        tbl[13] = mk(6'd0, 32'd0, {1'b1,5'd0}, 32'h55, 6'd0, 32'd0,
                     6'd0, 32'd0, 7'd0, 32'd0, 5'b00110);
        tbl[14] = mk(6'd0, 32'd0, 6'd0, 32'd0, 6'd0, 32'd0,
                     6'd0, 32'd0, 7'd0, 32'd0, 5'b00110);

        cpurst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        @(negedge clk);
        chk("rst_pend", 32'(wb_pending), 32'd0);
        chk("rst_wb1_vld", 32'(wb1_vld), 32'd0);
        chk("rst_lsu_rdy", 32'(lsu_wb_rdy), 32'd1);
        chk("rst_div_rdy", 32'(div_wb_rdy), 32'd1);
        chk("rst_err", 32'(wb_conflict_err), 32'd0);
        tick();
        cpurst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].ex_v, tbl[i].ex_rd, tbl[i].ex_d, tbl[i].l_v, tbl[i].l_rd, tbl[i].l_d,
                  tbl[i].d_v, tbl[i].d_rd, tbl[i].d_d);
            @(negedge clk);
            chk($sformatf("tbl%0d_wb0_vld", i),  32'(wb0_vld), 32'(tbl[i].o0_v));
            chk($sformatf("tbl%0d_wb0_rd", i),   32'(wb0_rd), 32'(tbl[i].o0_rd));
            chk($sformatf("tbl%0d_wb0_data", i), wb0_data, tbl[i].o0_d);
            chk($sformatf("tbl%0d_wb1_vld", i),  32'(wb1_vld), 32'(tbl[i].o1_v));
            chk($sformatf("tbl%0d_wb1_src", i),  32'(wb1_src), 32'(tbl[i].o1_src));
            chk($sformatf("tbl%0d_wb1_rd", i),   32'(wb1_rd), 32'(tbl[i].o1_rd));
            chk($sformatf("tbl%0d_wb1_data", i), wb1_data, tbl[i].o1_d);
            chk($sformatf("tbl%0d_pending", i),  32'(wb_pending), 32'(tbl[i].pend));
            chk($sformatf("tbl%0d_lsu_rdy", i),  32'(lsu_wb_rdy), 32'(tbl[i].lrdy));
            chk($sformatf("tbl%0d_div_rdy", i),  32'(div_wb_rdy), 32'(tbl[i].drdy));
            chk($sformatf("tbl%0d_err", i),      32'(wb_conflict_err), 32'(tbl[i].err));
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        starve_seq(1);
        starve_seq(2);

        // Reset while both buffers hold entries: they must vanish without a writeback
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'hAA, 1'b1, 5'd2, 32'hBB);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("mrst_pre_pend", 32'(wb_pending), 32'd2);
        #1 cpurst = 1'b1;
        #1;
        chk("mrst_pend", 32'(wb_pending), 32'd0);
        chk("mrst_wb1_vld", 32'(wb1_vld), 32'd0);
        chk("mrst_lsu_rdy", 32'(lsu_wb_rdy), 32'd1);
        chk("mrst_div_rdy", 32'(div_wb_rdy), 32'd1);
        tick();
        cpurst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("mrst_post%0d_wb1_vld", k), 32'(wb1_vld), 32'd0);
            chk($sformatf("mrst_post%0d_pend", k), 32'(wb_pending), 32'd0);
            tick();
        end

        // Random traffic against a queue-based model
        l_acc = 1'b1; d_acc = 1'b1; prev_conf = 1'b0; losses = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            lrate = (cyc < 1500) ? 90 : 45;
            ex_wb_vld  = ($urandom_range(0, 99) < 70);
            ex_wb_rd   = 5'($urandom_range(0, 7));
            ex_wb_data = $urandom;
            if (!(lsu_wb_vld && !l_acc)) begin
                lsu_wb_vld  = ($urandom_range(0, 99) < lrate);
                lsu_wb_rd   = 5'($urandom_range(0, 7));
                lsu_wb_data = $urandom;
            end
            if (!(div_wb_vld && !d_acc)) begin
                div_wb_vld  = ($urandom_range(0, 99) < 30);
                div_wb_rd   = 5'($urandom_range(0, 7));
                div_wb_data = $urandom;
            end
            @(negedge clk);
            m_gl = (lq.size() != 0) && !((dq.size() != 0) && (losses >= STARVE_MAX));
            m_gd = (dq.size() != 0) && !m_gl;
            e0v  = ex_wb_vld && (ex_wb_rd != 5'd0);
            e0rd = e0v ? ex_wb_rd : 5'd0;
            e0d  = e0v ? ex_wb_data : 32'd0;
            e1v  = m_gl || m_gd;
            e1rd = m_gl ? lq[0].rd : (m_gd ? dq[0].rd : 5'd0);
            e1d  = m_gl ? lq[0].d  : (m_gd ? dq[0].d  : 32'd0);
            chk("rnd_wb0_vld", 32'(wb0_vld), 32'(e0v));
            chk("rnd_wb0_rd", 32'(wb0_rd), 32'(e0rd));
            chk("rnd_wb0_data", wb0_data, e0d);
            chk("rnd_wb1_vld", 32'(wb1_vld), 32'(e1v));
            chk("rnd_wb1_src", 32'(wb1_src), 32'(m_gd));
            chk("rnd_wb1_rd", 32'(wb1_rd), 32'(e1rd));
            chk("rnd_wb1_data", wb1_data, e1d);
            chk("rnd_pending", 32'(wb_pending), 32'(lq.size() + dq.size()));
            chk("rnd_lsu_rdy", 32'(lsu_wb_rdy), 32'((lq.size() == 0) || m_gl));
            chk("rnd_div_rdy", 32'(div_wb_rdy), 32'((dq.size() == 0) || m_gd));
            chk("rnd_err", 32'(wb_conflict_err), 32'(prev_conf));
            l_acc = (lq.size() == 0) || m_gl;
            d_acc = (dq.size() == 0) || m_gd;
            prev_conf = e0v && e1v && (e0rd == e1rd);
            if (m_gd) begin
                losses = 0;
            end else if (dq.size() != 0) begin
                losses = (losses >= STARVE_MAX) ? STARVE_MAX : losses + 1;
            end
            if (m_gl) void'(lq.pop_front());
            if (m_gd) void'(dq.pop_front());
            if (lsu_wb_vld && l_acc && (lsu_wb_rd != 5'd0)) lq.push_back({lsu_wb_rd, lsu_wb_data});
            if (div_wb_vld && d_acc && (div_wb_rd != 5'd0)) dq.push_back({div_wb_rd, div_wb_data});
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
